// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================
// Package : wb_arbiter_pkg
// Purpose : shared write-back packet type, widths and tag age helper
// Rev     : 1.0
// ============================================================
package wb_arbiter_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 7;
    localparam int DATA_W    = 32;
    localparam int NUM_SRC   = 3;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_tag;
        logic [PREG_W-1:0]    pd;
        logic                 we;
        logic [DATA_W-1:0]    data;
    } wb_pkt_t;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_BR  = 2'd1,
        SRC_MEM = 2'd2
    } src_e;

    // Ages are distances from the ROB head, so wrap-around compares correctly.
    function automatic logic is_younger(input logic [ROB_IDX_W-1:0] tag,
                                        input logic [ROB_IDX_W-1:0] flush_tag,
                                        input logic [ROB_IDX_W-1:0] head,
                                        input int                   rob_size);
        int age_t;
        int age_f;
        age_t = (int'(tag) + rob_size - int'(head)) % rob_size;
        age_f = (int'(flush_tag) + rob_size - int'(head)) % rob_size;
        return age_t > age_f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================
// Module  : wb_fifo
// Purpose : per-source result queue with age-based flush and compaction
// Rev     : 1.0
// ============================================================
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_SIZE   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  wb_pkt_t              push_pkt,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [ROB_IDX_W-1:0] flush_tag,
    input  logic [ROB_IDX_W-1:0] rob_head,
    output wb_pkt_t              head_pkt,
    output logic                 head_ok,
    output logic                 ready,
    output logic                 overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_pkt_t          mem_q [FIFO_DEPTH];
    wb_pkt_t          mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             push_ok;
    logic             push_acc;

    always_comb begin
        logic [CNT_W-1:0] n;
        wb_pkt_t          e;
        n        = '0;
        e        = '0;
        full     = (cnt_q == CNT_W'(FIFO_DEPTH));
        ready    = !full;
        head_pkt = mem_q[rd_q];
        head_ok  = (cnt_q != '0) &&
                   !(flush && is_younger(mem_q[rd_q].rob_tag, flush_tag, rob_head, ROB_SIZE));
        push_ok  = push_pkt.valid &&
                   !(flush && is_younger(push_pkt.rob_tag, flush_tag, rob_head, ROB_SIZE));
        // A pop frees the slot this cycle, so a push at full still fits.
        push_acc = push_ok && (!full || pop);
        overflow = push_ok && full && !pop;
        wr_ptr   = rd_q + PTR_W'(cnt_q);
        mem_d    = mem_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        if (!flush) begin
            if (push_acc) begin
                mem_d[wr_ptr] = push_pkt;
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_acc) - CNT_W'(pop);
        end else begin
            // Rebuild survivors in program order starting at slot 0.
            rd_d = '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                e = mem_q[rd_q + PTR_W'(i)];
                if ((CNT_W'(i) < cnt_q) && !(pop && (i == 0)) &&
                    !is_younger(e.rob_tag, flush_tag, rob_head, ROB_SIZE)) begin
                    mem_d[n[PTR_W-1:0]] = e;
                    n = n + CNT_W'(1);
                end
            end
            if (push_acc) begin
                mem_d[n[PTR_W-1:0]] = push_pkt;
                n = n + CNT_W'(1);
            end
            cnt_d = n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================
// Module  : wb_arbiter
// Purpose : round-robin write-back arbiter of ALU/branch/MEM results onto the CDB
// Rev     : 1.0
// ============================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_SIZE   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  wb_pkt_t              alu_in,
    input  wb_pkt_t              b_in,
    input  wb_pkt_t              mem_in,
    output logic                 alu_ready,
    output logic                 b_ready,
    output logic                 mem_ready,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 mispredict,
    input  logic [ROB_IDX_W-1:0] mispredict_tag,
    output wb_pkt_t              cdb_out,
    output logic                 overflow_err
);

    wb_pkt_t            src_pkt  [NUM_SRC];
    wb_pkt_t            head_pkt [NUM_SRC];
    logic [NUM_SRC-1:0] head_ok;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] fifo_ready;
    logic [NUM_SRC-1:0] fifo_ovf;

    src_e    rr_q, rr_d;
    wb_pkt_t cdb_q, cdb_d;
    logic    ovf_q, ovf_d;

    assign src_pkt[SRC_ALU] = alu_in;
    assign src_pkt[SRC_BR]  = b_in;
    assign src_pkt[SRC_MEM] = mem_in;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
            wb_fifo #(
                .FIFO_DEPTH (FIFO_DEPTH),
                .ROB_SIZE   (ROB_SIZE)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push_pkt  (src_pkt[g]),
                .pop       (grant[g]),
                .flush     (mispredict),
                .flush_tag (mispredict_tag),
                .rob_head  (rob_head),
                .head_pkt  (head_pkt[g]),
                .head_ok   (head_ok[g]),
                .ready     (fifo_ready[g]),
                .overflow  (fifo_ovf[g])
            );
        end
    endgenerate

    always_comb begin
        logic       found;
        logic [1:0] win;
        logic [1:0] idx;
        int         pos;
        found = 1'b0;
        win   = SRC_ALU;
        idx   = SRC_ALU;
        pos   = 0;
        grant = '0;
        // Scan starting at the source after the previous winner.
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = int'(rr_q) + k;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            idx = 2'(pos);
            if (!found && head_ok[idx]) begin
                found      = 1'b1;
                win        = idx;
                grant[idx] = 1'b1;
            end
        end
        rr_d        = rr_q;
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        if (found) begin
            cdb_d       = head_pkt[win];
            cdb_d.valid = 1'b1;
            case (win)
                SRC_ALU: rr_d = SRC_BR;
                SRC_BR:  rr_d = SRC_MEM;
                default: rr_d = SRC_ALU;
            endcase
        end
        ovf_d = ovf_q | (|fifo_ovf);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q  <= SRC_ALU;
            cdb_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            cdb_q <= cdb_d;
            ovf_q <= ovf_d;
        end
    end

    assign alu_ready    = fifo_ready[SRC_ALU];
    assign b_ready      = fifo_ready[SRC_BR];
    assign mem_ready    = fifo_ready[SRC_MEM];
    assign cdb_out      = cdb_q;
    assign overflow_err = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================
// Module  : tb_wb_arbiter
// Purpose : self-checking bench for wb_arbiter
// Rev     : 1.0
// ============================================================
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int ROB   = 32;

    logic        clk = 1'b0;
    logic        reset;
    wb_pkt_t     src [3];
    logic        alu_ready, b_ready, mem_ready;
    logic [4:0]  rob_head;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    wb_pkt_t     cdb_out;
    logic        overflow_err;
    logic [2:0]  rdy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign rdy = {mem_ready, b_ready, alu_ready};

    wb_arbiter #(.FIFO_DEPTH(DEPTH), .ROB_SIZE(ROB)) dut (
        .clk            (clk),
        .reset          (reset),
        .alu_in         (src[0]),
        .b_in           (src[1]),
        .mem_in         (src[2]),
        .alu_ready      (alu_ready),
        .b_ready        (b_ready),
        .mem_ready      (mem_ready),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .cdb_out        (cdb_out),
        .overflow_err   (overflow_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_pkt_t mkp(input logic v, input int t);
        wb_pkt_t p;
        p.valid   = v;
        p.rob_tag = 5'(t);
        p.pd      = 7'(t + 40);
        p.we      = 1'b1;
        p.data    = 32'hC0DE0000 | 32'(t);
        return p;
    endfunction

    // ---------------- reference model: one queue per source ----------------
    wb_pkt_t mq [3][$];
    int      m_rr;
    wb_pkt_t m_cdb;
    logic    m_ovf;

    function automatic int age(input logic [4:0] t);
        return (int'(t) - int'(rob_head) + ROB) % ROB;
    endfunction

    function automatic bit younger(input logic [4:0] t);
        return mispredict && (age(t) > age(mispredict_tag));
    endfunction

    function automatic logic [2:0] m_rdy();
        return {mq[2].size() < DEPTH, mq[1].size() < DEPTH, mq[0].size() < DEPTH};
    endfunction

    task automatic model_step();
        int w;
        bit full_before [3];
        if (!reset) begin
            for (int s = 0; s < 3; s++) mq[s].delete();
            m_rr  = 0;
            m_cdb = '0;
            m_ovf = 1'b0;
            return;
        end
        for (int s = 0; s < 3; s++) full_before[s] = (mq[s].size() >= DEPTH);
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (m_rr + k) % 3;
            if (w < 0 && mq[s].size() > 0 && !younger(mq[s][0].rob_tag)) w = s;
        end
        if (w >= 0) begin
            m_cdb       = mq[w].pop_front();
            m_cdb.valid = 1'b1;
            m_rr        = (w + 1) % 3;
        end else begin
            m_cdb.valid = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            wb_pkt_t keep [$];
            keep = {};
            for (int i = 0; i < mq[s].size(); i++)
                if (!younger(mq[s][i].rob_tag)) keep.push_back(mq[s][i]);
            mq[s] = keep;
        end
        for (int s = 0; s < 3; s++) begin
            if (src[s].valid && !younger(src[s].rob_tag)) begin
                if (!full_before[s] || w == s) mq[s].push_back(src[s]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    function automatic wb_pkt_t rnd_pkt();
        wb_pkt_t p;
        p.valid   = ($urandom_range(0, 99) < 35);
        p.rob_tag = 5'($urandom);
        p.pd      = 7'($urandom);
        p.we      = 1'($urandom);
        p.data    = $urandom;
        return p;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rn;
        logic [2:0] v;
        int         ta, tb, tm;
        int         hd;
        logic       mis;
        int         mt;
        logic       ev;
        int         et;
        logic [2:0] erdy;
        logic       eovf;
    } vec_t;

    function automatic vec_t mkv(input logic rn, input logic [2:0] v, input int ta, input int tb,
                                 input int tm, input int hd, input logic mis, input int mt,
                                 input logic ev, input int et, input logic [2:0] erdy,
                                 input logic eovf);
        vec_t r;
        r.rn = rn; r.v = v; r.ta = ta; r.tb = tb; r.tm = tm; r.hd = hd; r.mis = mis;
        r.mt = mt; r.ev = ev; r.et = et; r.erdy = erdy; r.eovf = eovf;
        return r;
    endfunction

    vec_t tv [$];

    initial begin
        wb_pkt_t exp_pkt;
        reset          = 1'b0;
        rob_head       = '0;
        mispredict     = 1'b0;
        mispredict_tag = '0;
        for (int s = 0; s < 3; s++) src[s] = '0;

        // Reset state and single-push latency
        step();
        step();
        chk("reset cdb", 64'(cdb_out), 64'd0);
        chk("reset ready", 64'(rdy), 64'h7);
        chk("reset ovf", 64'(overflow_err), 64'd0);
        reset = 1'b1;
        step();
        chk("post-reset ready", 64'(rdy), 64'h7);
        src[0] = '{valid: 1'b1, rob_tag: 5'd3, pd: 7'd10, we: 1'b1, data: 32'hDEADBEEF};
        step();
        src[0] = '0;
        chk("lat edge E valid", 64'(cdb_out.valid), 64'd0);
        step();
        exp_pkt = '{valid: 1'b1, rob_tag: 5'd3, pd: 7'd10, we: 1'b1, data: 32'hDEADBEEF};
        chk("lat edge E+1 pkt", 64'(cdb_out), 64'(exp_pkt));
        step();
        chk("lat edge E+2 valid", 64'(cdb_out.valid), 64'd0);

        // Round-robin order
        tv.push_back(mkv(0, 3'b000,  0,  0,  0,  0, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b111,  1,  2,  3,  0, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1,  2, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1,  3, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 0,  3, 3'b111, 0));
        tv.push_back(mkv(1, 3'b011,  5,  4,  0,  0, 0, 0, 0,  3, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1,  5, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1,  4, 3'b111, 0));
        // Fill, overflow on MEM, drain; dropped tag 22 never appears
        tv.push_back(mkv(0, 3'b000,  0,  0,  0,  0, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b111, 10, 15, 20,  0, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b111, 11, 16, 21,  0, 0, 0, 1, 10, 3'b001, 0));
        tv.push_back(mkv(1, 3'b111, 12, 17, 22,  0, 0, 0, 1, 15, 3'b000, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1, 20, 3'b100, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1, 11, 3'b101, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1, 16, 3'b111, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1, 21, 3'b111, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1, 12, 3'b111, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 1, 17, 3'b111, 1));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 0, 17, 3'b111, 1));
        // All queues full, then reset
        tv.push_back(mkv(1, 3'b111,  1,  2,  3,  0, 0, 0, 0, 17, 3'b111, 1));
        tv.push_back(mkv(1, 3'b111,  4,  5,  6,  0, 0, 0, 1,  3, 3'b100, 1));
        tv.push_back(mkv(1, 3'b111,  7,  8,  9,  0, 0, 0, 1,  1, 3'b000, 1));
        tv.push_back(mkv(0, 3'b111, 10, 11, 12,  0, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0,  0, 0, 0, 0,  0, 3'b111, 0));
        // Flush with wrapped head 30: tags 31 and 1 survive, 4 is dropped
        tv.push_back(mkv(1, 3'b011, 31,  1,  0, 30, 0, 0, 0,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b001,  4,  0,  0, 30, 0, 0, 1, 31, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 0, 0, 1,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 1, 1, 0,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 0, 0, 0,  1, 3'b111, 0));
        // Younger head and younger incoming push in the flush cycle
        tv.push_back(mkv(1, 3'b001,  4,  0,  0, 30, 0, 0, 0,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b010,  0,  5,  0, 30, 1, 1, 0,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 0, 0, 0,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 0, 0, 0,  1, 3'b111, 0));
        // Branch's own packet survives; older push accepted during flush
        tv.push_back(mkv(1, 3'b011,  5,  1,  0, 30, 0, 0, 0,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b001,  0,  0,  0, 30, 1, 1, 1,  1, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 0, 0, 1,  0, 3'b111, 0));
        tv.push_back(mkv(1, 3'b000,  0,  0,  0, 30, 0, 0, 0,  0, 3'b111, 0));

        for (int i = 0; i < tv.size(); i++) begin
            reset          = tv[i].rn;
            src[0]         = mkp(tv[i].v[0], tv[i].ta);
            src[1]         = mkp(tv[i].v[1], tv[i].tb);
            src[2]         = mkp(tv[i].v[2], tv[i].tm);
            rob_head       = 5'(tv[i].hd);
            mispredict     = tv[i].mis;
            mispredict_tag = 5'(tv[i].mt);
            step();
            chk($sformatf("row%0d valid", i), 64'(cdb_out.valid), 64'(tv[i].ev));
            chk($sformatf("row%0d tag", i), 64'(cdb_out.rob_tag), 64'(tv[i].et));
            chk($sformatf("row%0d ready", i), 64'(rdy), 64'(tv[i].erdy));
            chk($sformatf("row%0d ovf", i), 64'(overflow_err), 64'(tv[i].eovf));
        end

        // Randomized traffic against the queue model
        for (int c = 0; c < 800; c++) begin
            reset = (c == 0 || $urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            for (int s = 0; s < 3; s++) src[s] = rnd_pkt();
            if ($urandom_range(0, 7) == 0) rob_head = 5'($urandom);
            mispredict     = ($urandom_range(0, 9) == 0);
            mispredict_tag = 5'($urandom);
            model_step();
            step();
            chk($sformatf("rand%0d cdb", c), 64'(cdb_out), 64'(m_cdb));
            chk($sformatf("rand%0d ready", c), 64'(rdy), 64'(m_rdy()));
            chk($sformatf("rand%0d ovf", c), 64'(overflow_err), 64'(m_ovf));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
